// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl
// Load/unload controller between narrow beat interfaces and a 128-bit AES core.
// It builds the key and the text from IN_W-bit beats. It then gives the core a
// one-cycle core_ld pulse and waits for core_done, with a timeout. The 128-bit
// result is then sent out as OUT_W-bit beats, MSB first.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous abort to IDLE, forgets the stored key
//   in_valid/in_ready     input handshake, in_data is the beat payload
//   key_keep              sampled on the first beat of a frame, reuse stored key
//   core_ld               one-cycle start pulse to the core
//   core_key/core_text    operand registers presented to the core
//   core_done/core_result core completion pulse and result
//   out_valid/out_ready   output handshake, out_data is the beat payload
//   out_last              marks the final output beat of a block
//   busy                  controller is not idle
//   err                   one-cycle pulse when the core times out
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for the first beat of a frame
// LOAD_KEY  | shifting key beats into key_reg
// LOAD_TEXT | shifting text beats into text_reg
// START     | core_ld high, operands stable
// WAIT      | waiting for core_done, timeout timer running
// UNLOAD    | streaming result_reg out, OUT_W bits per beat
module aes_stream_ctrl #(
    parameter int IN_W    = 4,
    parameter int OUT_W   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             key_keep,
    output logic             core_ld,
    output logic [127:0]     core_key,
    output logic [127:0]     core_text,
    input  logic             core_done,
    input  logic [127:0]     core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err
);

    localparam int NI        = 128 / IN_W;
    localparam int NO        = 128 / OUT_W;
    localparam int MAX_NI_NO = (NI > NO) ? NI : NO;
    localparam int CNT_MAX   = (MAX_NI_NO > TIMEOUT + 1) ? MAX_NI_NO : TIMEOUT + 1;
    localparam int CW        = $clog2(CNT_MAX);

    localparam logic [CW-1:0] NI_LAST = CW'(NI - 1);
    localparam logic [CW-1:0] NO_LAST = CW'(NO - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_TEXT,
        START,
        WAIT,
        UNLOAD
    } state_t;

    state_t        state;
    logic [127:0]  key_reg;
    logic [127:0]  text_reg;
    logic [127:0]  result_reg;
    logic          key_vld;
    logic [CW-1:0] cnt;
    logic [CW-1:0] timer;
    logic          accept;
    logic [127:0]  in_ext;

    assign in_ready  = ((state == IDLE) || (state == LOAD_KEY) || (state == LOAD_TEXT)) && !flush;
    assign accept    = in_valid && in_ready;
    assign in_ext    = 128'(in_data);
    assign core_key  = key_reg;
    assign core_text = text_reg;
    assign out_data  = result_reg[127 -: OUT_W];
    assign out_last  = out_valid && (cnt == NO_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_reg    <= '0;
            text_reg   <= '0;
            result_reg <= '0;
            key_vld    <= 1'b0;
            cnt        <= '0;
            timer      <= '0;
            core_ld    <= 1'b0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            key_vld   <= 1'b0;
            cnt       <= '0;
            timer     <= '0;
            core_ld   <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            core_ld <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (key_keep && key_vld) begin
                            text_reg <= (text_reg << IN_W) | in_ext;
                            if (NI == 1) begin
                                state   <= START;
                                core_ld <= 1'b1;
                                cnt     <= '0;
                            end else begin
                                state <= LOAD_TEXT;
                                cnt   <= CW'(1);
                            end
                        end else begin
                            // A new key is being written, so the old one is no longer usable.
                            key_reg <= (key_reg << IN_W) | in_ext;
                            if (NI == 1) begin
                                state   <= LOAD_TEXT;
                                key_vld <= 1'b1;
                                cnt     <= '0;
                            end else begin
                                state   <= LOAD_KEY;
                                key_vld <= 1'b0;
                                cnt     <= CW'(1);
                            end
                        end
                    end
                end
                LOAD_KEY: begin
                    if (accept) begin
                        key_reg <= (key_reg << IN_W) | in_ext;
                        if (cnt == NI_LAST) begin
                            state   <= LOAD_TEXT;
                            key_vld <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                LOAD_TEXT: begin
                    if (accept) begin
                        text_reg <= (text_reg << IN_W) | in_ext;
                        if (cnt == NI_LAST) begin
                            state   <= START;
                            core_ld <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                START: begin
                    // The timer counts down. Terminal count 0 is reached on the
                    // TIMEOUT-th WAIT cycle, so err rises TIMEOUT+1 cycles after core_ld.
                    state <= WAIT;
                    timer <= TO_LAST;
                end
                WAIT: begin
                    if (core_done) begin
                        result_reg <= core_result;
                        cnt        <= '0;
                        out_valid  <= 1'b1;
                        state      <= UNLOAD;
                    end else if (timer == '0) begin
                        err     <= 1'b1;
                        key_vld <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        timer <= timer - CW'(1);
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        result_reg <= result_reg << OUT_W;
                        if (cnt == NO_LAST) begin
                            out_valid <= 1'b0;
                            cnt       <= '0;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Testbench for aes_stream_ctrl. Two instances are built: 4-bit in / 8-bit out,
// and 8-bit in / 32-bit out. Both use TIMEOUT=15. The bench drives one instance
// at a time through shared stimulus, selected by 'sel'. Expected values come
// from a frame-level model of the block: the beats sent, whether a key is held,
// the core answer 5 cycles after core_ld, and the result sliced MSB first.
module tb_aes_stream_ctrl;

    localparam int TIMEOUT = 15;
    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] TXT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst_n;
    logic         sel;
    logic         flush, in_valid, key_keep, core_done, out_ready;
    logic [127:0] in_beat, core_result;

    logic         in_ready_a, core_ld_a, out_valid_a, out_last_a, busy_a, err_a;
    logic [127:0] core_key_a, core_text_a;
    logic [7:0]   out_data_a;
    logic         in_ready_b, core_ld_b, out_valid_b, out_last_b, busy_b, err_b;
    logic [127:0] core_key_b, core_text_b;
    logic [31:0]  out_data_b;

    logic         in_ready_m, core_ld_m, out_valid_m, out_last_m, busy_m, err_m;
    logic [127:0] core_key_m, core_text_m, out_data_m;

    int tests = 0;
    int fails = 0;
    bit           kv[2];
    logic [127:0] skey[2];

    aes_stream_ctrl #(.IN_W(4), .OUT_W(8), .TIMEOUT(TIMEOUT)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush & ~sel),
        .in_valid(in_valid & ~sel), .in_ready(in_ready_a), .in_data(in_beat[3:0]),
        .key_keep(key_keep), .core_ld(core_ld_a), .core_key(core_key_a),
        .core_text(core_text_a), .core_done(core_done & ~sel), .core_result(core_result),
        .out_valid(out_valid_a), .out_ready(out_ready & ~sel), .out_data(out_data_a),
        .out_last(out_last_a), .busy(busy_a), .err(err_a)
    );

    aes_stream_ctrl #(.IN_W(8), .OUT_W(32), .TIMEOUT(TIMEOUT)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush & sel),
        .in_valid(in_valid & sel), .in_ready(in_ready_b), .in_data(in_beat[7:0]),
        .key_keep(key_keep), .core_ld(core_ld_b), .core_key(core_key_b),
        .core_text(core_text_b), .core_done(core_done & sel), .core_result(core_result),
        .out_valid(out_valid_b), .out_ready(out_ready & sel), .out_data(out_data_b),
        .out_last(out_last_b), .busy(busy_b), .err(err_b)
    );

    assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
    assign core_ld_m   = sel ? core_ld_b   : core_ld_a;
    assign out_valid_m = sel ? out_valid_b : out_valid_a;
    assign out_last_m  = sel ? out_last_b  : out_last_a;
    assign busy_m      = sel ? busy_b      : busy_a;
    assign err_m       = sel ? err_b       : err_a;
    assign core_key_m  = sel ? core_key_b  : core_key_a;
    assign core_text_m = sel ? core_text_b : core_text_a;
    assign out_data_m  = sel ? 128'(out_data_b) : 128'(out_data_a);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] slice(input logic [127:0] w, input int idx, input int bw);
        logic [127:0] t;
        t = w << (bw * idx);
        return t >> (128 - bw);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; key_keep = 1'b0;
        core_done = 1'b0; out_ready = 1'b0;
    endtask

    // fl: 0 = no flush, 1 = flush together with core_done, 2 = flush in UNLOAD after 3 beats
    task automatic run_frame(input bit keep, input logic [127:0] key, input logic [127:0] text,
                             input logic [127:0] res, input bit gaps, input bit hang, input int fl);
        int iw, ow, ni, no, n_in, sent, got, ld_at, done_at, ld_cnt, last_acc;
        bit reuse, fl_now, timed_out, exp_ov;
        logic [127:0] ekey;
        logic [127:0] beats[$];
        iw = sel ? 8 : 4;
        ow = sel ? 32 : 8;
        ni = 128 / iw;
        no = 128 / ow;
        reuse = keep && kv[sel];
        ekey = reuse ? skey[sel] : key;
        beats = {};
        if (!reuse) for (int j = 0; j < ni; j++) beats.push_back(slice(key, j, iw));
        for (int j = 0; j < ni; j++) beats.push_back(slice(text, j, iw));
        n_in = beats.size();
        sent = 0; got = 0; ld_at = -1; done_at = -1; ld_cnt = 0; last_acc = -10;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            fl_now      = (fl == 1 && cyc == done_at) || (fl == 2 && got == 3);
            flush       = fl_now;
            in_valid    = (sent < n_in) && (!gaps || $urandom_range(0, 2) != 0);
            in_beat     = (sent < n_in) ? beats[sent] : rnd128();
            key_keep    = (sent == 0) ? keep : 1'($urandom_range(0, 1));
            out_ready   = !gaps || $urandom_range(0, 2) != 0;
            // spurious done pulses while loading must be ignored
            core_done   = (cyc == done_at) || (gaps && ld_at < 0 && $urandom_range(0, 7) == 0);
            core_result = (cyc == done_at) ? res : rnd128();
            #1;
            timed_out = hang && ld_at >= 0 && cyc == ld_at + TIMEOUT + 1;
            chk("in_ready", in_ready_m, !fl_now && (sent < n_in || timed_out));
            chk("err", err_m, timed_out);
            if (timed_out) begin
                chk("busy_after_timeout", busy_m, 0);
                chk("ld_count", ld_cnt, 1);
                kv[sel] = 1'b0;
                @(negedge clk); idle_inputs(); #1;
                chk("err_single_pulse", err_m, 0);
                return;
            end
            if (fl_now) begin
                @(negedge clk); idle_inputs(); #1;
                chk("out_valid_after_flush", out_valid_m, 0);
                chk("busy_after_flush", busy_m, 0);
                kv[sel] = 1'b0;
                return;
            end
            if (in_valid && in_ready_m) begin
                sent++;
                last_acc = cyc;
            end
            if (core_ld_m) begin
                ld_cnt++;
                ld_at = cyc;
                if (!hang) done_at = cyc + 5;
                chk("ld_latency", cyc, last_acc + 1);
                chk("ld_all_beats", sent, n_in);
                chk("core_key", core_key_m, ekey);
                chk("core_text", core_text_m, text);
            end
            exp_ov = done_at >= 0 && cyc > done_at && got < no;
            chk("out_valid", out_valid_m, exp_ov);
            if (out_valid_m) begin
                chk("out_data", out_data_m, slice(res, got, ow));
                chk("out_last", out_last_m, got == no - 1);
                chk("core_key_hold", core_key_m, ekey);
                if (out_ready) got++;
            end
            if (got == no) break;
        end
        @(negedge clk); idle_inputs(); #1;
        chk("frame_done", got, no);
        chk("ld_count", ld_cnt, 1);
        chk("busy_end", busy_m, 0);
        chk("out_valid_end", out_valid_m, 0);
        kv[sel] = 1'b1;
        skey[sel] = ekey;
    endtask

    task automatic send_key_beats(input int n, input logic [127:0] key);
        int iw;
        iw = sel ? 8 : 4;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b1; key_keep = 1'b0;
            in_beat = slice(key, j, iw);
            #1;
            chk("in_ready_key_beat", in_ready_m, 1);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_core_ld", core_ld_m, 0);
        chk("rst_core_key", core_key_m, 0);
        chk("rst_core_text", core_text_m, 0);
        chk("rst_out_valid", out_valid_m, 0);
        chk("rst_out_data", out_data_m, 0);
        chk("rst_out_last", out_last_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_err", err_m, 0);
    endtask

    initial begin
        sel = 1'b0; rst_n = 1'b0; in_beat = '0; core_result = '0;
        idle_inputs();
        kv[0] = 1'b0; kv[1] = 1'b0; skey[0] = '0; skey[1] = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values();
        sel = 1'b1; #1;
        check_reset_values();
        sel = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        chk("in_ready_after_reset", in_ready_m, 1);

        // 4-in / 8-out instance
        run_frame(1'b0, KEY0, TXT0, CT0, 1'b0, 1'b0, 0);
        run_frame(1'b1, rnd128(), TXT0, CT0, 1'b0, 1'b0, 0);

        // asynchronous reset mid-frame, then key_keep with no key held
        send_key_beats(20, rnd128());
        @(negedge clk); in_valid = 1'b0; #1;
        rst_n = 1'b0; #1;
        chk("async_rst_busy", busy_m, 0);
        chk("async_rst_key", core_key_m, 0);
        kv[0] = 1'b0; kv[1] = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_frame(1'b1, KEY0, TXT0, CT0, 1'b0, 1'b0, 0);

        // backpressure on both sides with random data
        for (int i = 0; i < 4; i++)
            run_frame(1'($urandom_range(0, 1)), rnd128(), rnd128(), rnd128(), 1'b1, 1'b0, 0);

        // timeout, then key_keep must fall back to a full key load
        run_frame(1'b0, KEY0, TXT0, CT0, 1'b1, 1'b1, 0);
        run_frame(1'b1, rnd128(), TXT0, CT0, 1'b1, 1'b0, 0);

        // flush after 10 key beats
        send_key_beats(10, KEY0);
        @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_beat = rnd128(); #1;
        chk("flush_in_ready", in_ready_m, 0);
        chk("flush_busy_in_cycle", busy_m, 1);
        @(negedge clk); idle_inputs(); #1;
        chk("flush_busy_after", busy_m, 0);
        chk("flush_in_ready_after", in_ready_m, 1);
        kv[0] = 1'b0;
        run_frame(1'b1, KEY0, TXT0, CT0, 1'b0, 1'b0, 0);

        // flush racing core_done, flush during unload
        run_frame(1'b1, rnd128(), TXT0, CT0, 1'b0, 1'b0, 1);
        run_frame(1'b1, KEY0, TXT0, CT0, 1'b0, 1'b0, 2);
        run_frame(1'b1, KEY0, TXT0, CT0, 1'b1, 1'b0, 0);

        // 8-in / 32-out instance
        sel = 1'b1;
        run_frame(1'b0, KEY0, TXT0, CT0, 1'b0, 1'b0, 0);
        run_frame(1'b1, rnd128(), TXT0, CT0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 2; i++)
            run_frame(1'($urandom_range(0, 1)), rnd128(), rnd128(), rnd128(), 1'b1, 1'b0, 0);
        run_frame(1'b0, rnd128(), rnd128(), CT0, 1'b1, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
